// File: rtl/id_scanner_if.sv
// ============================================================================
// Module      : id_scanner_if
// Description : Character-stream and status bundle for the identifier scanner.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface id_scanner_if #(
    parameter int LEN_W = 6,
    parameter int CNT_W = 16
) ();
    logic [7:0]       char;
    logic             valid;
    logic             clear;
    logic             out;
    logic             done;
    logic [LEN_W-1:0] alpha_len;
    logic [LEN_W-1:0] digit_len;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output char, valid, clear,
        input  out, done, alpha_len, digit_len, match_cnt
    );

    modport slave (
        input  char, valid, clear,
        output out, done, alpha_len, digit_len, match_cnt
    );
endinterface

`default_nettype wire

// File: rtl/id_scanner.sv
// ============================================================================
// Module      : id_scanner
// Description : Letter-run then digit-run identifier recognizer with run
//               lengths, termination pulse and saturating match counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module id_scanner #(
    parameter int MIN_ALPHA        = 1,
    parameter int MIN_DIGIT        = 1,
    parameter int LEN_W            = 6,
    parameter int CNT_W            = 16,
    parameter int ALLOW_UNDERSCORE = 0
) (
    input  wire logic clk,
    input  wire logic reset,
    id_scanner_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALPHA = 2'd1;
    localparam logic [1:0] S_DIGIT = 2'd2;

    localparam logic [LEN_W-1:0] c_len_max   = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] c_len_zero  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] c_len_one   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_min_alpha = LEN_W'(MIN_ALPHA);
    localparam logic [LEN_W-1:0] c_min_digit = LEN_W'(MIN_DIGIT);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_alpha_len;
    logic [LEN_W-1:0] r_digit_len;
    logic [CNT_W-1:0] r_match_cnt;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [LEN_W-1:0] w_alpha_nxt;
    logic [LEN_W-1:0] w_digit_nxt;
    logic             w_is_digit;
    logic             w_is_letter;
    logic             w_is_us;
    logic             w_out;
    logic             w_out_nxt;
    logic             w_rise;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    assign w_is_digit  = (bus.char >= 8'h30) && (bus.char <= 8'h39);
    assign w_is_letter = ((bus.char >= 8'h41) && (bus.char <= 8'h5A)) ||
                         ((bus.char >= 8'h61) && (bus.char <= 8'h7A)) ||
                         w_is_us;

    if (ALLOW_UNDERSCORE != 0) begin : g_underscore
        assign w_is_us = (bus.char == 8'h5F);
    end else begin : g_no_underscore
        assign w_is_us = 1'b0;
    end

    // ------------------------------------------------------------------
    // Next-state and run-length update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_alpha_nxt = r_alpha_len;
        w_digit_nxt = r_digit_len;
        if (bus.valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_letter) begin
                        w_state_nxt = S_ALPHA;
                        w_alpha_nxt = c_len_one;
                        w_digit_nxt = c_len_zero;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_alpha_nxt = c_len_zero;
                        w_digit_nxt = c_len_zero;
                    end
                end
                S_ALPHA: begin
                    if (w_is_letter) begin
                        if (r_alpha_len != c_len_max) begin
                            w_alpha_nxt = r_alpha_len + c_len_one;
                        end
                    end else if (w_is_digit && (r_alpha_len >= c_min_alpha)) begin
                        w_state_nxt = S_DIGIT;
                        w_digit_nxt = c_len_one;
                    end else begin
                        // Too-short letter run or a separator: discard the token.
                        w_state_nxt = S_IDLE;
                        w_alpha_nxt = c_len_zero;
                        w_digit_nxt = c_len_zero;
                    end
                end
                S_DIGIT: begin
                    if (w_is_digit) begin
                        if (r_digit_len != c_len_max) begin
                            w_digit_nxt = r_digit_len + c_len_one;
                        end
                    end else if (w_is_letter) begin
                        w_state_nxt = S_ALPHA;
                        w_alpha_nxt = c_len_one;
                        w_digit_nxt = c_len_zero;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_alpha_nxt = c_len_zero;
                        w_digit_nxt = c_len_zero;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_alpha_nxt = c_len_zero;
                    w_digit_nxt = c_len_zero;
                end
            endcase
        end
    end

    // Match flag is a pure function of the registered state; its next
    // value is needed to detect the rising edge for the counter.
    assign w_out     = (r_state == S_DIGIT) && (r_digit_len >= c_min_digit);
    assign w_out_nxt = (w_state_nxt == S_DIGIT) && (w_digit_nxt >= c_min_digit);
    assign w_rise    = !w_out && w_out_nxt;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_alpha_len <= c_len_zero;
            r_digit_len <= c_len_zero;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_alpha_len <= w_alpha_nxt;
            r_digit_len <= w_digit_nxt;
            r_done      <= bus.valid && !w_is_digit && w_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_match_cnt <= {CNT_W{1'b0}};
        end else if (bus.clear) begin
            r_match_cnt <= {CNT_W{1'b0}};
        end else if (w_rise && (r_match_cnt != c_cnt_max)) begin
            r_match_cnt <= r_match_cnt + c_cnt_one;
        end
    end

    assign bus.out       = w_out;
    assign bus.done      = r_done;
    assign bus.alpha_len = r_alpha_len;
    assign bus.digit_len = r_digit_len;
    assign bus.match_cnt = r_match_cnt;

endmodule

`default_nettype wire

// File: tb/tb_id_scanner.sv
// ============================================================================
// Module      : tb_id_scanner
// Description : Self-checking bench driving four parameterisations of
//               id_scanner with one shared directed character stream.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_id_scanner;

    logic       clk = 1'b0;
    logic       s_reset = 1'b1;
    logic [7:0] s_char = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_clear = 1'b0;
    bit         started = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instances: 0 default, 1 MIN_ALPHA=MIN_DIGIT=2, 2 underscore, 3 narrow
    id_scanner_if #(.LEN_W(6), .CNT_W(16)) if_a ();
    id_scanner_if #(.LEN_W(6), .CNT_W(16)) if_b ();
    id_scanner_if #(.LEN_W(6), .CNT_W(16)) if_c ();
    id_scanner_if #(.LEN_W(3), .CNT_W(2))  if_d ();

    assign if_a.char = s_char; assign if_a.valid = s_valid; assign if_a.clear = s_clear;
    assign if_b.char = s_char; assign if_b.valid = s_valid; assign if_b.clear = s_clear;
    assign if_c.char = s_char; assign if_c.valid = s_valid; assign if_c.clear = s_clear;
    assign if_d.char = s_char; assign if_d.valid = s_valid; assign if_d.clear = s_clear;

    id_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(6), .CNT_W(16), .ALLOW_UNDERSCORE(0))
        u_a (.clk(clk), .reset(s_reset), .bus(if_a.slave));
    id_scanner #(.MIN_ALPHA(2), .MIN_DIGIT(2), .LEN_W(6), .CNT_W(16), .ALLOW_UNDERSCORE(0))
        u_b (.clk(clk), .reset(s_reset), .bus(if_b.slave));
    id_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(6), .CNT_W(16), .ALLOW_UNDERSCORE(1))
        u_c (.clk(clk), .reset(s_reset), .bus(if_c.slave));
    id_scanner #(.MIN_ALPHA(1), .MIN_DIGIT(1), .LEN_W(3), .CNT_W(2), .ALLOW_UNDERSCORE(0))
        u_d (.clk(clk), .reset(s_reset), .bus(if_d.slave));

    int p_min_a [4] = '{1, 2, 1, 1};
    int p_min_d [4] = '{1, 2, 1, 1};
    int p_len_w [4] = '{6, 6, 6, 3};
    int p_cnt_w [4] = '{16, 16, 16, 2};
    int p_us    [4] = '{0, 0, 1, 0};

    // ------------------------------------------------------------------
    // Model: derive everything from the consumed-character history tail
    // ------------------------------------------------------------------
    logic [7:0] hist[$];
    int m_out [4];
    int m_done[4];
    int m_al  [4];
    int m_dl  [4];
    int m_cnt [4];

    function automatic bit is_d(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit is_l(input logic [7:0] c, input int us);
        return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)) ||
               ((us != 0) && (c == 8'h5F));
    endfunction

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    // Trailing digit run, and the letter run right before it, decide everything.
    task automatic eval_tail(input int i);
        int k;
        int d;
        int a;
        k = hist.size() - 1;
        d = 0;
        a = 0;
        while (k >= 0 && is_d(hist[k])) begin d++; k--; end
        while (k >= 0 && is_l(hist[k], p_us[i])) begin a++; k--; end
        m_out[i] = 0;
        m_al[i]  = 0;
        m_dl[i]  = 0;
        if (d > 0) begin
            if (a >= p_min_a[i]) begin
                m_al[i]  = sat(a, p_len_w[i]);
                m_dl[i]  = sat(d, p_len_w[i]);
                m_out[i] = (d >= p_min_d[i]) ? 1 : 0;
            end
        end else if (a > 0) begin
            m_al[i] = sat(a, p_len_w[i]);
        end
    endtask

    always @(posedge clk) begin
        if (s_reset) begin
            hist.delete();
            for (int i = 0; i < 4; i++) begin
                m_out[i] = 0; m_done[i] = 0; m_al[i] = 0; m_dl[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            if (s_valid) hist.push_back(s_char);
            for (int i = 0; i < 4; i++) begin
                int prev;
                prev = m_out[i];
                m_done[i] = (s_valid && !is_d(s_char) && prev == 1) ? 1 : 0;
                if (s_valid) eval_tail(i);
                if (prev == 0 && m_out[i] == 1) m_cnt[i] = sat(m_cnt[i] + 1, p_cnt_w[i]);
                if (s_clear) m_cnt[i] = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison of every instance against the model
    // ------------------------------------------------------------------
    task automatic cmp_one(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL model_%s inst%0d t=%0t actual=%0d expected=%0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic cmp_inst(input int i, input int o, input int dn, input int al,
                            input int dl, input int cn);
        cmp_one("out", i, o, m_out[i]);
        cmp_one("done", i, dn, m_done[i]);
        cmp_one("alpha_len", i, al, m_al[i]);
        cmp_one("digit_len", i, dl, m_dl[i]);
        cmp_one("match_cnt", i, cn, m_cnt[i]);
    endtask

    always @(negedge clk) begin
        if (started) begin
            cmp_inst(0, int'(if_a.out), int'(if_a.done), int'(if_a.alpha_len),
                     int'(if_a.digit_len), int'(if_a.match_cnt));
            cmp_inst(1, int'(if_b.out), int'(if_b.done), int'(if_b.alpha_len),
                     int'(if_b.digit_len), int'(if_b.match_cnt));
            cmp_inst(2, int'(if_c.out), int'(if_c.done), int'(if_c.alpha_len),
                     int'(if_c.digit_len), int'(if_c.match_cnt));
            cmp_inst(3, int'(if_d.out), int'(if_d.done), int'(if_d.alpha_len),
                     int'(if_d.digit_len), int'(if_d.match_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers and literal checks
    // ------------------------------------------------------------------
    task automatic lit(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic tick(input logic [7:0] c, input logic v, input logic cl, input logic r);
        @(negedge clk);
        #1;
        s_char  = c;
        s_valid = v;
        s_clear = cl;
        s_reset = r;
        @(posedge clk);
        #2;
    endtask

    task automatic feed(input logic [7:0] c);
        tick(c, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic gap();
        tick(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic feed_str(input string s);
        for (int k = 0; k < s.len(); k++) feed(s[k]);
    endtask

    string s1 = "ab12 ";
    int e1_out[5] = '{0, 0, 1, 1, 0};
    int e1_dl [5] = '{0, 0, 1, 2, 0};
    int e1_dn [5] = '{0, 0, 0, 0, 1};

    initial begin
        do_reset();
        do_reset();
        started = 1'b1;
        lit("rst_out", int'(if_a.out), 0);
        lit("rst_done", int'(if_a.done), 0);
        lit("rst_alpha", int'(if_d.alpha_len), 0);
        lit("rst_cnt", int'(if_b.match_cnt), 0);

        // Basic token "ab12 "
        for (int k = 0; k < 5; k++) begin
            feed(s1[k]);
            lit($sformatf("t1_out_%0d", k), int'(if_a.out), e1_out[k]);
            lit($sformatf("t1_dlen_%0d", k), int'(if_a.digit_len), e1_dl[k]);
            lit($sformatf("t1_done_%0d", k), int'(if_a.done), e1_dn[k]);
        end
        lit("t1_cnt", int'(if_a.match_cnt), 1);
        lit("t1_model_cnt", m_cnt[0], 1);
        gap();
        lit("t1_done_drop", int'(if_a.done), 0);

        // "a1" gap "b2#"
        do_reset();
        feed("a");
        feed("1");
        lit("t2_out_1", int'(if_a.out), 1);
        lit("t2_cnt_1", int'(if_a.match_cnt), 1);
        for (int k = 0; k < 3; k++) begin
            gap();
            lit("t2_gap_out", int'(if_a.out), 1);
            lit("t2_gap_alen", int'(if_a.alpha_len), 1);
            lit("t2_gap_dlen", int'(if_a.digit_len), 1);
            lit("t2_gap_done", int'(if_a.done), 0);
            lit("t2_gap_cnt", int'(if_a.match_cnt), 1);
        end
        feed("b");
        lit("t2_b_out", int'(if_a.out), 0);
        lit("t2_b_done", int'(if_a.done), 1);
        lit("t2_b_alen", int'(if_a.alpha_len), 1);
        feed("2");
        lit("t2_2_out", int'(if_a.out), 1);
        lit("t2_2_cnt", int'(if_a.match_cnt), 2);
        lit("t2_2_done", int'(if_a.done), 0);
        feed("#");
        lit("t2_hash_done", int'(if_a.done), 1);
        lit("t2_hash_out", int'(if_a.out), 0);
        lit("t2_hash_cnt", int'(if_a.match_cnt), 2);

        // Minimum run lengths of 2 on instance 1
        do_reset();
        feed("a");
        lit("t3_a_alen", int'(if_b.alpha_len), 1);
        feed("1");
        lit("t3_1_alen", int'(if_b.alpha_len), 0);
        lit("t3_1_dlen", int'(if_b.digit_len), 0);
        lit("t3_1_out", int'(if_b.out), 0);
        feed("2");
        lit("t3_2_out", int'(if_b.out), 0);
        feed_str("ab1");
        lit("t3_ab1_out", int'(if_b.out), 0);
        lit("t3_ab1_dlen", int'(if_b.digit_len), 1);
        lit("t3_ab1_alen", int'(if_b.alpha_len), 2);
        feed("2");
        lit("t3_ab12_out", int'(if_b.out), 1);
        lit("t3_ab12_cnt", int'(if_b.match_cnt), 1);
        lit("t3_default_cnt", int'(if_a.match_cnt), 2);

        // Underscore class
        do_reset();
        feed("_");
        lit("t4_us_alen_on", int'(if_c.alpha_len), 1);
        lit("t4_us_alen_off", int'(if_a.alpha_len), 0);
        feed("x");
        lit("t4_x_alen_off", int'(if_a.alpha_len), 1);
        feed("9");
        lit("t4_9_out_on", int'(if_c.out), 1);
        lit("t4_9_alen_on", int'(if_c.alpha_len), 2);
        lit("t4_9_out_off", int'(if_a.out), 1);
        lit("t4_9_alen_off", int'(if_a.alpha_len), 1);

        // Reset mid-token, then clear on the rising edge of out
        do_reset();
        feed_str("a1");
        lit("t5_pre_out", int'(if_a.out), 1);
        lit("t5_pre_cnt", int'(if_a.match_cnt), 1);
        tick(" ", 1'b1, 1'b0, 1'b1);
        lit("t5_rst_out", int'(if_a.out), 0);
        lit("t5_rst_done", int'(if_a.done), 0);
        lit("t5_rst_cnt", int'(if_a.match_cnt), 0);
        feed("a");
        tick("1", 1'b1, 1'b1, 1'b0);
        lit("t5_clr_out", int'(if_a.out), 1);
        lit("t5_clr_cnt", int'(if_a.match_cnt), 0);
        feed("2");
        lit("t5_hold_cnt", int'(if_a.match_cnt), 0);
        feed(" ");
        lit("t5_done", int'(if_a.done), 1);
        lit("t5_done_cnt", int'(if_a.match_cnt), 0);

        // Saturation on the narrow instance
        do_reset();
        feed_str("abcdefghij");
        lit("t6_alen_sat", int'(if_d.alpha_len), 7);
        lit("t6_alen_wide", int'(if_a.alpha_len), 10);
        feed("1");
        lit("t6_cnt_1", int'(if_d.match_cnt), 1);
        for (int k = 0; k < 4; k++) feed_str("a1");
        lit("t6_cnt_sat", int'(if_d.match_cnt), 3);
        lit("t6_cnt_wide", int'(if_a.match_cnt), 5);
        lit("t6_model_cnt_sat", m_cnt[3], 3);
        feed_str("123456789");
        lit("t6_dlen_sat", int'(if_d.digit_len), 7);
        lit("t6_dlen_wide", int'(if_a.digit_len), 10);
        gap();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
